hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
Second-generation pipeline hazard unit for the 5-stage RV32I core (F/D/E/M/W). It keeps the existing forwarding, load-use stall and branch-flush duties, parametrised in register-address width. It adds two multi-cycle stall sources: an E-stage multiply/divide unit of configurable latency, tracked by an internal FSM and counter, and an M-stage data-memory ready handshake. It sits between datapath and controller and drives every stage-register stall and flush.

Parameters:
REG_ADDR_W, 5, width of register-address fields.
MD_LAT, 4, total E-stage cycles a mul/div op occupies (≥1).
CNT_W, 3, width of the MD latency counter; must satisfy 2^CNT_W > MD_LAT.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
Di_rs1, Di_rs2  in  REG_ADDR_W  D-stage source registers
Ei_rs1, Ei_rs2, Ei_rd  in  REG_ADDR_W  E-stage source and destination registers
Mi_rd, Wi_rd  in  REG_ADDR_W  M/W destination registers
Ei_PCSrc  in  2  next-PC select; 00 = PC+4
Ei_resultSrc, Mi_resultSrc  in  2  00 ALU, 01 load, 10 immPlus
Mi_regWrite, Wi_regWrite  in  1  register-write enables
Ei_mdOp  in  1  E holds a mul/div op
Mi_memReq  in  1  M holds a load/store
Mi_memReady  in  1  data memory completes this cycle
Eo_forwardIn1Src, Eo_forwardIn2Src  out  2  11 M ALUOut, 10 M immPlus, 01 W result, 00 register file
Fo_stall, Do_stall, Eo_stall, Mo_stall  out  1  hold the stage register
Do_flush, Eo_flush, Mo_flush, Wo_flush  out  1  bubble the stage register
Eo_mdDone  out  1  MD result valid in E this cycle

Behaviour:
- Forwarding, per operand, is combinational. For x0, output 00.
  - If the operand matches Mi_rd, Mi_regWrite=1 and Mi_resultSrc=00, output 11.
  - If it matches Mi_rd with Mi_resultSrc=10, output 10.
  - Otherwise, if it matches Wi_rd with Wi_regWrite=1, output 01.
  - An M match that is a load, or has regWrite=0, falls through to the W check.
- lwStall = Ei_resultSrc==01 & Ei_rd!=0 & (Di_rs1==Ei_rd | Di_rs2==Ei_rd).
- memWait = Mi_memReq & !Mi_memReady.
- MD FSM has states IDLE, BUSY, DONE; cnt is CNT_W bits wide.
  - IDLE: if Ei_mdOp and MD_LAT>1, go to BUSY with cnt=MD_LAT-1. If MD_LAT==1, stay in IDLE and assert Eo_mdDone combinationally.
  - BUSY: cnt decrements every cycle, including during memWait. At cnt==1, go to DONE.
  - DONE: Eo_mdDone=1. Leave to IDLE when !memWait; otherwise hold.
- mdBusy = Ei_mdOp & (state==IDLE & MD_LAT>1 | state==BUSY). Total stall = MD_LAT-1 cycles.
- Priority, highest first:
  1. memWait: Fo/Do/Eo/Mo_stall=1, Wo_flush=1, all other flushes 0. lwStall and branch effects are deferred until release.
  2. mdBusy: Fo/Do/Eo_stall=1, Mo_flush=1. Branch flush is suppressed.
  3. lwStall: Fo/Do_stall=1, Eo_flush=1.
  4. Ei_PCSrc!=00: Do_flush=1, Eo_flush=1.
- All outputs are combinational from inputs and state, except the FSM state and cnt, which update on rising clk.
- Reset values: state=IDLE, cnt=0. With idle inputs, all stalls/flushes are 0, forwards are 00 and Eo_mdDone is 0.
- rst_n low mid-operation returns the FSM to IDLE immediately; no done pulse is emitted.
- Ei_mdOp dropping while BUSY (E flushed by reset only) returns to IDLE on the next edge.

Optional Feature:
HAZARD_PERF_EN: when defined, add outputs perf_stallCycles[31:0] and perf_flushCount[31:0].
- perf_stallCycles counts cycles with Fo_stall=1.
- perf_flushCount counts cycles with Do_flush=1.
- Both saturate at 0xFFFFFFFF and reset to 0 on rst_n low.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Forward: Ei_rs1=5, Mi_rd=5, Mi_regWrite=1, Mi_resultSrc=00; Ei_rs2=6, Wi_rd=6, Wi_regWrite=1 -> forward1=11, forward2=01. Same with rs1=0 -> forward1=00.
- Load-use: Ei_resultSrc=01, Ei_rd=7, Di_rs2=7 -> Fo/Do_stall=1, Eo_flush=1 for one cycle. With Ei_rd=0 -> no stall.
- MD latency: MD_LAT=4, Ei_mdOp held -> stalls for 3 cycles, Eo_mdDone=1 on the 4th, back to IDLE the next cycle.
- Mem wait overlapping MD: memWait asserted during the BUSY countdown -> Mo_stall=1, Wo_flush=1, counter still reaches DONE, and DONE is held until Mi_memReady=1.
- Branch under stall: Ei_PCSrc=01 with lwStall=1 -> Eo_flush=1, Do_flush=1, Fo_stall=1. Ei_PCSrc=01 with memWait=1 -> no flush.
- Reset: rst_n low while BUSY with cnt=2 -> state=IDLE, all outputs 0. Under HAZARD_PERF_EN, counters clear.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use/branch hazards, multi-cycle MD and data-memory stalls.
// Latency: all hazard outputs are combinational; only the MD FSM state and counter are registered.
// Backpressure: memWait freezes F..M, an MD op freezes F..E, and load-use freezes F/D. Optional macro: HAZARD_PERF_EN.
module hazard_unit_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Di_rs1,
    input  logic [REG_ADDR_W-1:0] Di_rs2,
    input  logic [REG_ADDR_W-1:0] Ei_rs1,
    input  logic [REG_ADDR_W-1:0] Ei_rs2,
    input  logic [REG_ADDR_W-1:0] Ei_rd,
    input  logic [REG_ADDR_W-1:0] Mi_rd,
    input  logic [REG_ADDR_W-1:0] Wi_rd,
    input  logic [1:0]            Ei_PCSrc,
    input  logic [1:0]            Ei_resultSrc,
    input  logic [1:0]            Mi_resultSrc,
    input  logic                  Mi_regWrite,
    input  logic                  Wi_regWrite,
    input  logic                  Ei_mdOp,
    input  logic                  Mi_memReq,
    input  logic                  Mi_memReady,
    output logic [1:0]            Eo_forwardIn1Src,
    output logic [1:0]            Eo_forwardIn2Src,
    output logic                  Fo_stall,
    output logic                  Do_stall,
    output logic                  Eo_stall,
    output logic                  Mo_stall,
    output logic                  Do_flush,
    output logic                  Eo_flush,
    output logic                  Mo_flush,
    output logic                  Wo_flush,
    output logic                  Eo_mdDone
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stallCycles,
    output logic [31:0]           perf_flushCount
`endif
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam bit              MD_MULTI = (MD_LAT > 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lw_stall, mem_wait, md_busy, branch;

    // M-stage loads and non-writing instructions fall through to the W check.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [1:0]            m_src,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (rs == m_rd && m_we && m_src == 2'b00)
                sel = 2'b11;
            else if (rs == m_rd && m_we && m_src == 2'b10)
                sel = 2'b10;
            else if (rs == w_rd && w_we)
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        Eo_forwardIn1Src = fwd_sel(Ei_rs1, Mi_rd, Mi_regWrite, Mi_resultSrc, Wi_rd, Wi_regWrite);
        Eo_forwardIn2Src = fwd_sel(Ei_rs2, Mi_rd, Mi_regWrite, Mi_resultSrc, Wi_rd, Wi_regWrite);
    end

    assign lw_stall = (Ei_resultSrc == 2'b01) && (Ei_rd != '0) &&
                      ((Di_rs1 == Ei_rd) || (Di_rs2 == Ei_rd));
    assign mem_wait = Mi_memReq && !Mi_memReady;
    assign branch   = (Ei_PCSrc != 2'b00);
    assign md_busy  = Ei_mdOp && ((state == MD_IDLE && MD_MULTI) || state == MD_BUSY);
    assign Eo_mdDone = (state == MD_DONE) || (!MD_MULTI && Ei_mdOp);

    // The counter keeps running under memWait; only DONE waits for memory.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MD_IDLE: begin
                if (Ei_mdOp && MD_MULTI) begin
                    cnt_nxt   = MD_LOAD;
                    state_nxt = (MD_LOAD == CNT_ONE) ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (!Ei_mdOp) begin
                    cnt_nxt   = '0;
                    state_nxt = MD_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt_nxt == CNT_ONE)
                        state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!mem_wait) begin
                    cnt_nxt   = '0;
                    state_nxt = MD_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load-use and branch combine; both are deferred behind MD and memory stalls.
    always_comb begin
        Fo_stall = 1'b0;
        Do_stall = 1'b0;
        Eo_stall = 1'b0;
        Mo_stall = 1'b0;
        Do_flush = 1'b0;
        Eo_flush = 1'b0;
        Mo_flush = 1'b0;
        Wo_flush = 1'b0;
        if (mem_wait) begin
            Fo_stall = 1'b1;
            Do_stall = 1'b1;
            Eo_stall = 1'b1;
            Mo_stall = 1'b1;
            Wo_flush = 1'b1;
        end else if (md_busy) begin
            Fo_stall = 1'b1;
            Do_stall = 1'b1;
            Eo_stall = 1'b1;
            Mo_flush = 1'b1;
        end else begin
            Fo_stall = lw_stall;
            Do_stall = lw_stall;
            Eo_flush = lw_stall || branch;
            Do_flush = branch;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stallCycles <= '0;
            perf_flushCount  <= '0;
        end else begin
            if (Fo_stall && perf_stallCycles != 32'hFFFF_FFFF)
                perf_stallCycles <= perf_stallCycles + 32'd1;
            if (Do_flush && perf_flushCount != 32'hFFFF_FFFF)
                perf_flushCount <= perf_flushCount + 32'd1;
        end
    end
`endif

endmodule
